// File: rtl/iic_eeprom_master.sv
// iic_eeprom_master: I2C bus initiator for single-byte writes and random reads
// against 256x8 paged EEPROM units. SCL is push-pull and SDA is open-drain.
module iic_eeprom_master #(
    parameter int unsigned QTR_DIV = 25,
    parameter logic [3:0]  DEV_ID  = 4'b1010
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       rw,
    input  logic [2:0] page,
    input  logic [7:0] addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       SCL,
    inout  wire        SDA
);

    localparam int unsigned      CNT_W   = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(QTR_DIV - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_TX_CTRL_W,
        S_TX_ADDR,
        S_TX_DATA,
        S_TX_CTRL_R,
        S_ACK_CHK,
        S_RESTART,
        S_RX_DATA,
        S_NACK,
        S_STOP,
        S_DONE
    } state_t;

    state_t           state;
    state_t           ack_next;
    logic [CNT_W-1:0] qcnt;
    logic             tick;
    logic [1:0]       qtr;
    logic [2:0]       bit_cnt;
    logic [2:0]       bit_nx;
    logic             sda_low;
    logic             sda_s1;
    logic             sda_s2;
    logic             rw_q;
    logic [2:0]       page_q;
    logic [7:0]       addr_q;
    logic [7:0]       data_q;
    logic [7:0]       shreg;
    logic [7:0]       tx_byte;
    logic [7:0]       ctrl_w;
    logic [7:0]       ctrl_r;

    // Open-drain data line: only ever pull low or let go.
    assign SDA    = sda_low ? 1'b0 : 1'bz;
    assign ctrl_w = {DEV_ID, page_q, 1'b0};
    assign ctrl_r = {DEV_ID, page_q, 1'b1};
    assign bit_nx = bit_cnt - 3'd1;

    // Quarter-period timebase; tick is registered, so it trails the wrap by one clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qcnt <= '0;
            tick <= 1'b0;
        end else if (!busy) begin
            qcnt <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (qcnt == CNT_MAX);
            qcnt <= (qcnt == CNT_MAX) ? '0 : qcnt + CNT_W'(1);
        end
    end

    // Two-flop synchronizer for the incoming SDA level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sda_s1 <= 1'b1;
            sda_s2 <= 1'b1;
        end else begin
            sda_s1 <= SDA;
            sda_s2 <= sda_s1;
        end
    end

    // Byte currently being shifted out, selected by the transmit state.
    always_comb begin
        tx_byte = 8'h00;
        case (state)
            S_TX_CTRL_W: tx_byte = ctrl_w;
            S_TX_ADDR:   tx_byte = addr_q;
            S_TX_DATA:   tx_byte = data_q;
            S_TX_CTRL_R: tx_byte = ctrl_r;
            default:     tx_byte = 8'h00;
        endcase
    end

    // Transaction sequencer; every bit slot is Q0..Q3 with SCL rising after Q1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            ack_next <= S_IDLE;
            qtr      <= 2'd0;
            bit_cnt  <= 3'd0;
            sda_low  <= 1'b0;
            SCL      <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            ack_err  <= 1'b0;
            rd_data  <= 8'h00;
            rw_q     <= 1'b0;
            page_q   <= 3'd0;
            addr_q   <= 8'h00;
            data_q   <= 8'h00;
            shreg    <= 8'h00;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    SCL     <= 1'b1;
                    sda_low <= 1'b0;
                    qtr     <= 2'd0;
                    if (start) begin
                        rw_q    <= rw;
                        page_q  <= page;
                        addr_q  <= addr;
                        data_q  <= wr_data;
                        ack_err <= 1'b0;
                        busy    <= 1'b1;
                        sda_low <= 1'b1;
                        state   <= S_START;
                    end
                end

                S_START: begin
                    if (tick) begin
                        if (qtr == 2'd1) begin
                            qtr     <= 2'd0;
                            SCL     <= 1'b0;
                            bit_cnt <= 3'd7;
                            sda_low <= ~ctrl_w[7];
                            state   <= S_TX_CTRL_W;
                        end else begin
                            qtr <= qtr + 2'd1;
                        end
                    end
                end

                S_TX_CTRL_W, S_TX_ADDR, S_TX_DATA, S_TX_CTRL_R: begin
                    if (tick) begin
                        qtr <= qtr + 2'd1;
                        if (qtr == 2'd1) begin
                            SCL <= 1'b1;
                        end else if (qtr == 2'd3) begin
                            SCL <= 1'b0;
                            if (bit_cnt == 3'd0) begin
                                sda_low <= 1'b0;
                                state   <= S_ACK_CHK;
                                case (state)
                                    S_TX_CTRL_W: ack_next <= S_TX_ADDR;
                                    S_TX_ADDR:   ack_next <= rw_q ? S_RESTART : S_TX_DATA;
                                    S_TX_CTRL_R: ack_next <= S_RX_DATA;
                                    default:     ack_next <= S_STOP;
                                endcase
                            end else begin
                                bit_cnt <= bit_nx;
                                sda_low <= ~tx_byte[bit_nx];
                            end
                        end
                    end
                end

                S_ACK_CHK: begin
                    if (tick) begin
                        qtr <= qtr + 2'd1;
                        if (qtr == 2'd1) begin
                            SCL <= 1'b1;
                        end else if (qtr == 2'd3) begin
                            SCL <= 1'b0;
                            if (sda_s2) begin
                                ack_err <= 1'b1;
                                sda_low <= 1'b1;
                                state   <= S_STOP;
                            end else begin
                                state <= ack_next;
                                case (ack_next)
                                    S_TX_ADDR: begin
                                        bit_cnt <= 3'd7;
                                        sda_low <= ~addr_q[7];
                                    end
                                    S_TX_DATA: begin
                                        bit_cnt <= 3'd7;
                                        sda_low <= ~data_q[7];
                                    end
                                    S_RX_DATA: begin
                                        bit_cnt <= 3'd7;
                                        sda_low <= 1'b0;
                                    end
                                    S_RESTART: sda_low <= 1'b0;
                                    default:   sda_low <= 1'b1;
                                endcase
                            end
                        end
                    end
                end

                S_RESTART: begin
                    if (tick) begin
                        qtr <= qtr + 2'd1;
                        if (qtr == 2'd0) begin
                            SCL <= 1'b1;
                        end else if (qtr == 2'd1) begin
                            sda_low <= 1'b1;
                        end else if (qtr == 2'd3) begin
                            SCL     <= 1'b0;
                            bit_cnt <= 3'd7;
                            sda_low <= ~ctrl_r[7];
                            state   <= S_TX_CTRL_R;
                        end
                    end
                end

                S_RX_DATA: begin
                    if (tick) begin
                        qtr <= qtr + 2'd1;
                        if (qtr == 2'd1) begin
                            SCL <= 1'b1;
                        end else if (qtr == 2'd3) begin
                            SCL            <= 1'b0;
                            shreg[bit_cnt] <= sda_s2;
                            if (bit_cnt == 3'd0) begin
                                state <= S_NACK;
                            end else begin
                                bit_cnt <= bit_nx;
                            end
                        end
                    end
                end

                S_NACK: begin
                    if (tick) begin
                        qtr <= qtr + 2'd1;
                        if (qtr == 2'd1) begin
                            SCL <= 1'b1;
                        end else if (qtr == 2'd3) begin
                            SCL     <= 1'b0;
                            sda_low <= 1'b1;
                            state   <= S_STOP;
                        end
                    end
                end

                S_STOP: begin
                    if (tick) begin
                        qtr <= qtr + 2'd1;
                        if (qtr == 2'd0) begin
                            SCL <= 1'b1;
                        end else if (qtr == 2'd1) begin
                            sda_low <= 1'b0;
                        end else if (qtr == 2'd3) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_DONE;
                            if (rw_q && !ack_err) begin
                                rd_data <= shreg;
                            end
                        end
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iic_eeprom_master.sv
// tb_iic_eeprom_master: directed vectors against two behavioural EEPROM units
// (pages 0 and 1) sharing one pulled-up SDA/SCL bus.
module tb_iic_eeprom_master;

    localparam int unsigned QTR   = 4;
    localparam int          LIMIT = 200 * QTR + 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [2:0] page = 3'd0;
    logic [7:0] addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       SCL;
    wire        SDA;

    iic_eeprom_master #(.QTR_DIV(QTR), .DEV_ID(4'b1010)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .rw      (rw),
        .page    (page),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err),
        .SCL     (SCL),
        .SDA     (SDA)
    );

    always #5 clk = ~clk;

    // Bus: pull-up plus open-drain slave drivers.
    logic [1:0] drv = 2'b00;
    pullup (SDA);
    assign SDA = (|drv) ? 1'b0 : 1'bz;

    // Slave and monitor state.
    logic [7:0] mem [2][256];
    logic [7:0] sh  [2];
    logic [7:0] ptr [2];
    int         bn  [2];
    int         ph  [2];
    logic       act [2];
    logic       snd [2];
    logic       rdn [2];
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    logic [7:0] mon_sh = 8'h00;
    int         mon_n = 8;
    int         n_starts = 0;
    logic [7:0] ctrl_log [$];
    logic       last_mack = 1'b0;

    int passed = 0;
    int total  = 0;

    // Bus monitor plus two EEPROM units, all sampled away from the active edge.
    always @(negedge clk) begin
        logic       sda_b;
        logic       scl_b;
        logic [7:0] tb_byte;
        sda_b = SDA;
        scl_b = SCL;
        if (p_scl && scl_b && p_sda && !sda_b) begin
            n_starts++;
            mon_n = 0;
        end else if (!p_scl && scl_b && mon_n < 8) begin
            mon_sh = {mon_sh[6:0], sda_b};
            mon_n++;
            if (mon_n == 8) ctrl_log.push_back(mon_sh);
        end
        for (int u = 0; u < 2; u++) begin
            if (p_scl && scl_b && p_sda && !sda_b) begin
                act[u] = 1'b1; ph[u] = 0; bn[u] = 0; snd[u] = 1'b0; drv[u] = 1'b0;
            end else if (p_scl && scl_b && !p_sda && sda_b) begin
                act[u] = 1'b0; snd[u] = 1'b0; drv[u] = 1'b0;
            end else if (act[u] && !p_scl && scl_b) begin
                bn[u]++;
                if (bn[u] <= 8 && !snd[u]) sh[u] = {sh[u][6:0], sda_b};
                if (bn[u] == 9 && snd[u]) last_mack = sda_b;
            end else if (act[u] && p_scl && !scl_b) begin
                if (bn[u] <= 7) begin
                    if (snd[u]) begin
                        tb_byte = mem[u][ptr[u]];
                        drv[u] = ~tb_byte[7 - bn[u]];
                    end
                end else if (bn[u] == 8) begin
                    if (snd[u]) begin
                        drv[u] = 1'b0;
                    end else if (ph[u] == 0) begin
                        if (sh[u][7:1] == {4'b1010, 3'(u)}) begin
                            drv[u] = 1'b1; rdn[u] = sh[u][0]; ph[u] = 1;
                        end else begin
                            act[u] = 1'b0;
                        end
                    end else if (ph[u] == 1) begin
                        ptr[u] = sh[u]; drv[u] = 1'b1; ph[u] = 2;
                    end else if (ph[u] == 2) begin
                        mem[u][ptr[u]] = sh[u]; drv[u] = 1'b1; ph[u] = 3;
                    end else begin
                        act[u] = 1'b0;
                    end
                end else begin
                    drv[u] = 1'b0;
                    bn[u]  = 0;
                    if (snd[u]) begin
                        act[u] = 1'b0; snd[u] = 1'b0;
                    end else if (ph[u] == 1 && rdn[u]) begin
                        snd[u] = 1'b1;
                        tb_byte = mem[u][ptr[u]];
                        drv[u] = ~tb_byte[7];
                    end
                end
            end
        end
        p_scl = scl_b;
        p_sda = sda_b;
    end

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        total++;
        if (act_v !== exp_v) $display("FAIL %s: got %0h required %0h", nm, act_v, exp_v);
        else passed++;
    endtask

    // One command from strobe to done; cyc counts clk edges from the strobe.
    task automatic run_txn(input logic r, input logic [2:0] pg, input logic [7:0] ad,
                           input logic [7:0] wd, input bit poke,
                           output int cyc, output bit to, output logic busy_acc);
        @(posedge clk); #1;
        ctrl_log.delete();
        n_starts = 0;
        last_mack = 1'b0;
        rw = r; page = pg; addr = ad; wr_data = wd; start = 1'b1;
        cyc = 0; to = 1'b1; busy_acc = 1'b0;
        for (int n = 1; n <= LIMIT; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin start = 1'b0; busy_acc = busy; end
            if (poke && n == 40) start = 1'b1;
            if (poke && n == 41) start = 1'b0;
            if (done) begin cyc = n; to = 1'b0; break; end
        end
    endtask

    typedef struct {
        logic       rw;
        logic [2:0] page;
        logic [7:0] addr;
        logic [7:0] wdat;
        logic       exp_err;
        logic [7:0] exp_rd;
        int         ticks;
        logic [7:0] exp_ctrl;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int         cyc;
        bit         to;
        logic       bacc;
        int         n_done;
        int         n_busy;
        logic [7:0] c0;
        logic [7:0] c1;

        for (int u = 0; u < 2; u++) begin
            for (int a = 0; a < 256; a++) mem[u][a] = 8'hFF;
            sh[u] = 8'h00; ptr[u] = 8'h00; bn[u] = 0; ph[u] = 0;
            act[u] = 1'b0; snd[u] = 1'b0; rdn[u] = 1'b0;
        end

        //            rw    page  addr   wdat   err   rd     ticks ctrl
        vecs[0]  = '{1'b0, 3'd0, 8'h5A, 8'hC3, 1'b0, 8'h00, 114, 8'hA0};
        vecs[1]  = '{1'b1, 3'd0, 8'h5A, 8'h00, 1'b0, 8'hC3, 154, 8'hA0};
        vecs[2]  = '{1'b0, 3'd2, 8'h10, 8'h77, 1'b1, 8'hC3,  42, 8'hA4};
        vecs[3]  = '{1'b0, 3'd0, 8'h00, 8'h11, 1'b0, 8'hC3, 114, 8'hA0};
        vecs[4]  = '{1'b0, 3'd1, 8'h00, 8'h22, 1'b0, 8'hC3, 114, 8'hA2};
        vecs[5]  = '{1'b1, 3'd0, 8'h00, 8'h00, 1'b0, 8'h11, 154, 8'hA0};
        vecs[6]  = '{1'b1, 3'd1, 8'h00, 8'h00, 1'b0, 8'h22, 154, 8'hA2};
        vecs[7]  = '{1'b1, 3'd2, 8'h00, 8'h00, 1'b1, 8'h22,  42, 8'hA4};
        vecs[8]  = '{1'b0, 3'd0, 8'hFF, 8'hA5, 1'b0, 8'h22, 114, 8'hA0};
        vecs[9]  = '{1'b1, 3'd0, 8'hFF, 8'h00, 1'b0, 8'hA5, 154, 8'hA0};
        vecs[10] = '{1'b1, 3'd1, 8'h5A, 8'h00, 1'b0, 8'hFF, 154, 8'hA2};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_scl", 32'(SCL), 32'h1);
        chk("rst_sda", 32'(SDA), 32'h1);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ackerr", 32'(ack_err), 32'h0);
        chk("rst_rd", 32'(rd_data), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table.
        for (int i = 0; i < 11; i++) begin
            run_txn(vecs[i].rw, vecs[i].page, vecs[i].addr, vecs[i].wdat, 1'b0, cyc, to, bacc);
            chk($sformatf("v%0d_timeout", i), 32'(to), 32'h0);
            chk($sformatf("v%0d_busy_acc", i), 32'(bacc), 32'h1);
            chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].ticks * int'(QTR) + 2));
            chk($sformatf("v%0d_busy_done", i), 32'(busy), 32'h0);
            chk($sformatf("v%0d_ackerr", i), 32'(ack_err), 32'(vecs[i].exp_err));
            chk($sformatf("v%0d_rd", i), 32'(rd_data), 32'(vecs[i].exp_rd));
            c0 = (ctrl_log.size() > 0) ? ctrl_log[0] : 8'h00;
            chk($sformatf("v%0d_ctrl0", i), 32'(c0), 32'(vecs[i].exp_ctrl));
            if (vecs[i].rw && !vecs[i].exp_err) begin
                c1 = (ctrl_log.size() > 1) ? ctrl_log[1] : 8'h00;
                chk($sformatf("v%0d_ctrl1", i), 32'(c1), 32'(vecs[i].exp_ctrl | 8'h01));
                chk($sformatf("v%0d_starts", i), 32'(n_starts), 32'h2);
                chk($sformatf("v%0d_nack", i), 32'(last_mack), 32'h1);
            end
            if (!vecs[i].rw && !vecs[i].exp_err) begin
                chk($sformatf("v%0d_mem", i), 32'(mem[int'(vecs[i].page)][vecs[i].addr]),
                    32'(vecs[i].wdat));
            end
        end

        // Start strobes while busy and in the done cycle must be ignored.
        run_txn(1'b0, 3'd0, 8'h80, 8'h5C, 1'b1, cyc, to, bacc);
        chk("busy_timeout", 32'(to), 32'h0);
        chk("busy_cycles", 32'(cyc), 32'(114 * int'(QTR) + 2));
        rw = 1'b1; page = 3'd1; addr = 8'h00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0;
        n_busy = 0;
        for (int n = 0; n < 16 * int'(QTR); n++) begin
            @(posedge clk); #1;
            if (done) n_done++;
            if (busy) n_busy++;
        end
        chk("donecyc_extra_done", 32'(n_done), 32'h0);
        chk("donecyc_busy", 32'(n_busy), 32'h0);
        chk("busy_mem", 32'(mem[0][8'h80]), 32'h5C);

        // Reset in the middle of the address byte.
        @(posedge clk); #1;
        rw = 1'b0; page = 3'd0; addr = 8'h33; wr_data = 8'hEE; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (45 * int'(QTR)) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_scl", 32'(SCL), 32'h1);
        chk("midrst_sda", 32'(SDA), 32'h1);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_rd", 32'(rd_data), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_txn(1'b0, 3'd0, 8'h33, 8'h44, 1'b0, cyc, to, bacc);
        chk("postrst_timeout", 32'(to), 32'h0);
        chk("postrst_cycles", 32'(cyc), 32'(114 * int'(QTR) + 2));
        chk("postrst_ackerr", 32'(ack_err), 32'h0);
        chk("postrst_mem", 32'(mem[0][8'h33]), 32'h44);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
